csa_select_serial: RTL and testbench
====================================

Name: csa_select_serial

Overview:
- Block-serial carry-select adder: the resolving end of the dual-sum block interface.
- Each cycle it processes one BLOCK-bit slice of the operands.
- For each slice it forms both candidate sums (carry-in 0 and carry-in 1), then selects one using the running carry resolved from the previous slice.
- Operands enter and results leave through valid/ready handshakes. The block sits between operand staging and result consumers in the datapath.

Parameters:
- WIDTH, 32, operand and sum width in bits.
- BLOCK, 8, slice width. Must divide WIDTH exactly; NBLK = WIDTH/BLOCK. Elaboration error otherwise.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands a, b, c_in are valid.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- c_in  input  1  carry into bit 0.
- out_valid  output  1  sum and c_out are valid.
- out_ready  input  1  consumer accepts the result.
- sum  output  WIDTH  (a + b + c_in) mod 2^WIDTH.
- c_out  output  1  carry out of bit WIDTH-1.
- busy  output  1  high in RUN or DONE.

Behaviour:
- Reset (async assert, sync release):
  - state = IDLE; sum = 0; c_out = 0; out_valid = 0.
  - Internal operand registers, carry register and slice index all clear to 0.
  - in_ready = 1 and busy = 0 immediately after reset.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready: capture a, b into registers, carry_r <= c_in, idx <= 0, go to RUN.
  - in_valid without acceptance has no effect.
- RUN (in_ready = 0): each cycle, operate on slice idx = bits [idx*BLOCK +: BLOCK].
  - s0 = a_s + b_s (BLOCK+1 bits, carry-in 0).
  - s1 = a_s + b_s + 1 (BLOCK+1 bits, carry-in 1).
  - Selected = carry_r ? s1 : s0.
  - The selected low BLOCK bits are written to sum slice idx. carry_r <= selected bit BLOCK.
  - When idx = NBLK-1: c_out <= selected carry, out_valid <= 1, go to DONE. Otherwise idx <= idx+1.
- Latency:
  - Handshake at edge E0; slices 0..NBLK-1 are resolved at edges E1..E_NBLK.
  - out_valid is high after edge E_NBLK, i.e. NBLK cycles after acceptance.
- DONE:
  - sum, c_out and out_valid are held stable until out_ready = 1.
  - On out_valid & out_ready: out_valid <= 0, go to IDLE.
  - No same-cycle accept of a new operand; in_ready rises the cycle after the output handshake. Throughput is one result per NBLK+2 cycles.
- sum register:
  - Not cleared between operations. Slices are overwritten in order.
  - Its contents are only meaningful while out_valid = 1.
- Operand inputs:
  - Changes to a, b, c_in after capture do not affect the result in progress.
  - in_valid is ignored outside IDLE.
- Wrap-around: the carry out of the top slice goes to c_out only; sum wraps modulo 2^WIDTH.
- NBLK = 1 (BLOCK = WIDTH): RUN lasts exactly one cycle.
- Reset asserted during RUN or DONE:
  - The operation is aborted, all outputs return to reset values, and no result is emitted.
  - A pending DONE result is discarded.
- Simultaneous out_ready and in_valid in DONE: only the output handshake occurs; in_valid is sampled again in IDLE.

Test Plan:
1. Carry ripple (WIDTH=32, BLOCK=8): a=0xFFFFFFFF, b=0x00000001, c_in=0, out_ready=1 -> out_valid exactly 4 cycles after acceptance, sum=0x00000000, c_out=1, then in_ready=1 one cycle later.
2. Carry-in: a=0x12345678, b=0x9ABCDEF0, c_in=1 -> sum=0xACF13569, c_out=0. Then a=0x80000000, b=0x80000000, c_in=0 -> sum=0x00000000, c_out=1.
3. Backpressure: hold out_ready=0 for 10 cycles after out_valid rises -> sum, c_out, out_valid unchanged; in_ready=0; busy=1. Raise out_ready -> out_valid drops next edge.
4. Reset mid-operation: assert rst_n=0 two cycles after acceptance -> out_valid=0, sum=0, c_out=0, in_ready=1 immediately; no result appears afterward.
5. Back-to-back: in_valid held high with changing operands, out_ready=1 -> one acceptance per 6 cycles (NBLK+2). Results match a reference model over 1000 random vectors, including operand changes during RUN.
6. NBLK=1 (WIDTH=8, BLOCK=8): a=0xFF, b=0xFF, c_in=1 -> out_valid one cycle after acceptance, sum=0xFF, c_out=1.

Source files
------------

// File: rtl/csa_select_serial.sv
// Block-serial carry-select adder.
// Operands are captured on an input handshake. Each RUN cycle resolves one
// BLOCK-bit slice. For that slice both candidate sums (carry-in 0 and
// carry-in 1) are formed, and the running carry from the previous slice
// selects one of them. The finished result is held in DONE until the
// consumer takes it.
module csa_select_serial #(
  parameter int WIDTH = 32,
  parameter int BLOCK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             busy
);

  localparam int NBLK = WIDTH / BLOCK;
  localparam int IW   = (NBLK > 1) ? $clog2(NBLK) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // A slice width that does not tile the operand is a configuration error.
  if ((WIDTH % BLOCK) != 0) begin : g_bad_block
    $error("csa_select_serial: BLOCK must divide WIDTH exactly");
  end

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             carry_q, carry_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             c_out_q, c_out_d;
  logic             out_valid_q, out_valid_d;
  logic             in_ready_q, in_ready_d;
  logic             busy_q, busy_d;

  logic [BLOCK-1:0] a_slc_s, b_slc_s;
  logic [BLOCK:0]   s0_s, s1_s, sel_s;

  // Candidate sums for the current slice and carry-based selection.
  always_comb begin
    a_slc_s = a_q[idx_q*BLOCK +: BLOCK];
    b_slc_s = b_q[idx_q*BLOCK +: BLOCK];
    s0_s    = {1'b0, a_slc_s} + {1'b0, b_slc_s};
    s1_s    = {1'b0, a_slc_s} + {1'b0, b_slc_s} + {{BLOCK{1'b0}}, 1'b1};
    if (carry_q) begin
      sel_s = s1_s;
    end else begin
      sel_s = s0_s;
    end
  end

  // Next-state logic for the IDLE/RUN/DONE controller and its datapath.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    carry_d     = carry_q;
    idx_d       = idx_q;
    sum_d       = sum_q;
    c_out_d     = c_out_q;
    out_valid_d = out_valid_q;
    in_ready_d  = in_ready_q;
    busy_d      = busy_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d        = a;
          b_d        = b;
          carry_d    = c_in;
          idx_d      = {IW{1'b0}};
          state_d    = ST_RUN;
          in_ready_d = 1'b0;
          busy_d     = 1'b1;
        end else begin
          state_d    = ST_IDLE;
        end
      end
      ST_RUN: begin
        sum_d[idx_q*BLOCK +: BLOCK] = sel_s[BLOCK-1:0];
        carry_d                     = sel_s[BLOCK];
        if (idx_q == IW'(NBLK - 1)) begin
          c_out_d     = sel_s[BLOCK];
          out_valid_d = 1'b1;
          state_d     = ST_DONE;
        end else begin
          idx_d       = idx_q + IW'(1);
        end
      end
      ST_DONE: begin
        // The output handshake alone; a new operand waits for IDLE.
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
          in_ready_d  = 1'b1;
          busy_d      = 1'b0;
        end else begin
          state_d     = ST_DONE;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        busy_d      = 1'b0;
      end
    endcase
  end

  // State and datapath registers; reset clears everything and opens the input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      a_q         <= {WIDTH{1'b0}};
      b_q         <= {WIDTH{1'b0}};
      carry_q     <= 1'b0;
      idx_q       <= {IW{1'b0}};
      sum_q       <= {WIDTH{1'b0}};
      c_out_q     <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      carry_q     <= carry_d;
      idx_q       <= idx_d;
      sum_q       <= sum_d;
      c_out_q     <= c_out_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign c_out     = c_out_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_csa_select_serial.sv
// Directed bench for csa_select_serial: a 32/8 instance for the main
// scenarios and an 8/8 instance for the single-slice case.
module tb_csa_select_serial;

  logic        clk;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready, c_in, c_out, busy;
  logic [31:0] a, b, sum;
  logic        in_valid8, in_ready8, out_valid8, out_ready8, c_in8, c_out8, busy8;
  logic [7:0]  a8, b8, sum8;

  int total = 0;
  int bad   = 0;

  csa_select_serial #(.WIDTH(32), .BLOCK(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .c_in(c_in), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .c_out(c_out), .busy(busy)
  );

  csa_select_serial #(.WIDTH(8), .BLOCK(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .c_in(c_in8), .out_valid(out_valid8), .out_ready(out_ready8),
    .sum(sum8), .c_out(c_out8), .busy(busy8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one operand set, wait for acceptance, then count cycles to out_valid.
  // Called and returns at posedge+1. lat is the number of edges after acceptance.
  task automatic do_op(input logic [31:0] ta, input logic [31:0] tb, input logic tc,
                       output int lat, output logic [31:0] s_o, output logic co_o);
    int n;
    a = ta; b = tb; c_in = tc; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = ~ta; b = ~tb; c_in = ~tc;
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(posedge clk); #1; lat++;
    end
    s_o = sum; co_o = c_out;
  endtask

  task automatic test_reset();
    total++; if (in_ready !== 1'b1)   begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    total++; if (busy !== 1'b0)       begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (out_valid !== 1'b0)  begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    total++; if (sum !== 32'h0)       begin bad++; $display("FAIL reset_sum got=%h want=0", sum); end
    total++; if (c_out !== 1'b0)      begin bad++; $display("FAIL reset_c_out got=%b want=0", c_out); end
  endtask

  task automatic test_carry_ripple();
    int lat; logic [31:0] s; logic co;
    out_ready = 1'b1;
    do_op(32'hFFFFFFFF, 32'h00000001, 1'b0, lat, s, co);
    total++; if (lat !== 4)        begin bad++; $display("FAIL ripple_latency got=%0d want=4", lat); end
    total++; if (s !== 32'h0)      begin bad++; $display("FAIL ripple_sum got=%h want=00000000", s); end
    total++; if (co !== 1'b1)      begin bad++; $display("FAIL ripple_c_out got=%b want=1", co); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL ripple_in_ready_done got=%b want=0", in_ready); end
    @(posedge clk); #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL ripple_in_ready_after got=%b want=1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL ripple_out_valid_after got=%b want=0", out_valid); end
  endtask

  task automatic test_carry_in();
    int lat; logic [31:0] s; logic co;
    out_ready = 1'b1;
    do_op(32'h12345678, 32'h9ABCDEF0, 1'b1, lat, s, co);
    total++; if (s !== 32'hACF13569) begin bad++; $display("FAIL cin_sum got=%h want=acf13569", s); end
    total++; if (co !== 1'b0)        begin bad++; $display("FAIL cin_c_out got=%b want=0", co); end
    @(posedge clk); #1;
    do_op(32'h80000000, 32'h80000000, 1'b0, lat, s, co);
    total++; if (s !== 32'h0)   begin bad++; $display("FAIL wrap_sum got=%h want=00000000", s); end
    total++; if (co !== 1'b1)   begin bad++; $display("FAIL wrap_c_out got=%b want=1", co); end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    int lat; logic [31:0] s; logic co;
    out_ready = 1'b0;
    do_op(32'h0000FFFF, 32'h00000001, 1'b0, lat, s, co);
    total++; if (s !== 32'h00010000) begin bad++; $display("FAIL bp_sum got=%h want=00010000", s); end
    in_valid = 1'b1; a = 32'h5; b = 32'h6; c_in = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      total++; if (out_valid !== 1'b1)   begin bad++; $display("FAIL bp_out_valid cyc=%0d got=%b want=1", i, out_valid); end
      total++; if (sum !== 32'h00010000) begin bad++; $display("FAIL bp_hold_sum cyc=%0d got=%h want=00010000", i, sum); end
      total++; if (c_out !== 1'b0)       begin bad++; $display("FAIL bp_hold_c_out cyc=%0d got=%b want=0", i, c_out); end
      total++; if (in_ready !== 1'b0)    begin bad++; $display("FAIL bp_in_ready cyc=%0d got=%b want=0", i, in_ready); end
      total++; if (busy !== 1'b1)        begin bad++; $display("FAIL bp_busy cyc=%0d got=%b want=1", i, busy); end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_release_out_valid got=%b want=0", out_valid); end
    total++; if (in_ready !== 1'b1)  begin bad++; $display("FAIL bp_release_in_ready got=%b want=1", in_ready); end
    total++; if (busy !== 1'b0)      begin bad++; $display("FAIL bp_release_busy got=%b want=0", busy); end
    @(posedge clk); #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL bp_no_accept_busy got=%b want=0", busy); end
  endtask

  task automatic test_reset_mid();
    int seen;
    out_ready = 1'b1;
    a = 32'h11111111; b = 32'h22222222; c_in = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rstmid_out_valid got=%b want=0", out_valid); end
    total++; if (sum !== 32'h0)      begin bad++; $display("FAIL rstmid_sum got=%h want=00000000", sum); end
    total++; if (c_out !== 1'b0)     begin bad++; $display("FAIL rstmid_c_out got=%b want=0", c_out); end
    total++; if (in_ready !== 1'b1)  begin bad++; $display("FAIL rstmid_in_ready got=%b want=1", in_ready); end
    total++; if (busy !== 1'b0)      begin bad++; $display("FAIL rstmid_busy got=%b want=0", busy); end
    #2 rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    total++; if (seen !== 0) begin bad++; $display("FAIL rstmid_no_result got=%0d want=0", seen); end
  endtask

  task automatic test_back_to_back();
    logic [32:0] expq[$];
    logic [32:0] e;
    int cyc, acc, last, hs;
    out_ready = 1'b1;
    in_valid = 1'b1;
    cyc = 0; acc = 0; last = -1; hs = 0;
    while ((acc < 1000 || expq.size() > 0) && cyc < 20000) begin
      a = $urandom; b = $urandom; c_in = 1'($urandom_range(0, 1));
      if (out_valid) begin
        hs++;
        if (expq.size() == 0) begin
          total++; bad++; $display("FAIL b2b_unexpected_result sum=%h", sum);
        end else begin
          e = expq.pop_front();
          total++; if ({c_out, sum} !== e) begin bad++; $display("FAIL b2b_result got=%h want=%h", {c_out, sum}, e); end
        end
      end
      if (acc < 1000) begin
        if (in_ready) begin
          expq.push_back({1'b0, a} + {1'b0, b} + {32'h0, c_in});
          if (last >= 0) begin
            total++; if (cyc - last !== 6) begin bad++; $display("FAIL b2b_interval got=%0d want=6", cyc - last); end
          end
          last = cyc; acc++;
        end else begin
          last = last;
        end
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk); #1; cyc++;
    end
    in_valid = 1'b0;
    total++; if (hs !== 1000) begin bad++; $display("FAIL b2b_result_count got=%0d want=1000", hs); end
  endtask

  task automatic test_single_block();
    out_ready8 = 1'b1;
    a8 = 8'hFF; b8 = 8'hFF; c_in8 = 1'b1; in_valid8 = 1'b1;
    total++; if (in_ready8 !== 1'b1) begin bad++; $display("FAIL nblk1_in_ready got=%b want=1", in_ready8); end
    @(posedge clk); #1;
    in_valid8 = 1'b0; a8 = 8'h00; b8 = 8'h00; c_in8 = 1'b0;
    total++; if (out_valid8 !== 1'b0) begin bad++; $display("FAIL nblk1_early got=%b want=0", out_valid8); end
    @(posedge clk); #1;
    total++; if (out_valid8 !== 1'b1) begin bad++; $display("FAIL nblk1_out_valid got=%b want=1", out_valid8); end
    total++; if (sum8 !== 8'hFF)      begin bad++; $display("FAIL nblk1_sum got=%h want=ff", sum8); end
    total++; if (c_out8 !== 1'b1)     begin bad++; $display("FAIL nblk1_c_out got=%b want=1", c_out8); end
    @(posedge clk); #1;
    total++; if (out_valid8 !== 1'b0) begin bad++; $display("FAIL nblk1_release got=%b want=0", out_valid8); end
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; a = 32'h0; b = 32'h0; c_in = 1'b0;
    in_valid8 = 1'b0; out_ready8 = 1'b0; a8 = 8'h0; b8 = 8'h0; c_in8 = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_carry_ripple();
    test_carry_in();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    test_single_block();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
